// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock,
// with a start/done handshake and a leading-zero blanking mask for the display.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_mask
);

  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);
  localparam logic [DIGITS-1:0] MASK_RESET = ~(DIGITS'(1));

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Largest binary input must fit in DIGITS decimal digits; reject at elaboration.
  generate
    if (BIN_W < 1 || BIN_W > 62 || DIGITS < 1) begin : g_bad_width
      $error("bin2bcd_seq: BIN_W must be 1..62 and DIGITS at least 1");
    end
    else if (pow10(DIGITS) <= ((longint'(1) << BIN_W) - 1)) begin : g_too_few_digits
      $error("bin2bcd_seq: DIGITS too small to hold 2**BIN_W-1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t               state;
  logic [BIN_W-1:0]     shift_reg;
  logic [4*DIGITS-1:0]  scratch;
  logic [CNT_W-1:0]     bit_cnt;
  logic [4*DIGITS-1:0]  adjusted;
  logic [DIGITS-1:0]    mask_next;

  always_comb begin
    adjusted = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // A digit blanks only if it and every digit above it are zero; units never blank.
  always_comb begin : mask_calc
    logic zero_above;
    zero_above = 1'b1;
    mask_next  = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above   = zero_above & (scratch[4*i +: 4] == 4'd0);
      mask_next[i] = zero_above;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shift_reg  <= '0;
      scratch    <= '0;
      bit_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd_out    <= '0;
      blank_mask <= MASK_RESET;
    end
    else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            shift_reg <= bin_in;
            scratch   <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b1;
            state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scratch   <= {adjusted[4*DIGITS-2:0], shift_reg[BIN_W-1]};
          shift_reg <= shift_reg << 1;
          bit_cnt   <= bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) state <= S_DONE;
        end
        S_DONE: begin
          done       <= 1'b1;
          bcd_out    <= scratch;
          blank_mask <= mask_next;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
